// File: rtl/soundrive_fifo.sv
// Covox/Soundrive DAC front-end: latches CPU OUT writes into N 8-bit channels,
// either directly (legacy) or through per-channel FIFOs drained once per sample frame.
module soundrive_fifo #(
  parameter int                    CHANNELS   = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    RATE_DIV   = 635,
  parameter logic [CHANNELS*8-1:0] CH_PORTS   = {8'h5F, 8'h4F, 8'h1F, 8'h0F},
  parameter logic [7:0]            COVOX_PORT = 8'hFB,
  parameter logic [7:0]            STAT_PORT  = 8'hBF
) (
  input  logic                    clk28,
  input  logic                    rst,
  input  logic                    en_soundrive,
  input  logic                    en_covox,
  input  logic                    en_fifo,
  input  logic [7:0]              bus_a,
  input  logic [7:0]              bus_d,
  input  logic                    bus_ioreq,
  input  logic                    bus_wr,
  input  logic                    bus_rd,
  output logic [7:0]              d_out,
  output logic                    d_oe,
  output logic [CHANNELS*8-1:0]   ch_out,
  output logic                    frame_stb
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(RATE_DIV + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [CHANNELS-1:0] hit_d, hit_q;
  logic                wr_hit_d, wr_hit_q;
  logic                wr_dly_d, wr_dly_q;
  logic [7:0]          data_d, data_q;
  logic                rd_act, rd_d, rd_q;
  logic [DW-1:0]       div_d, div_q;
  logic                ovf_d, ovf_q, unr_d, unr_q;
  logic [7:0]          mem_d  [CHANNELS][DEPTH];
  logic [7:0]          mem_q  [CHANNELS][DEPTH];
  logic [AW-1:0]       wptr_d [CHANNELS];
  logic [AW-1:0]       wptr_q [CHANNELS];
  logic [AW-1:0]       rptr_d [CHANNELS];
  logic [AW-1:0]       rptr_q [CHANNELS];
  logic [LW-1:0]       lvl_d  [CHANNELS];
  logic [LW-1:0]       lvl_q  [CHANNELS];
  logic [7:0]          out_d  [CHANNELS];
  logic [7:0]          out_q  [CHANNELS];
  logic                push_stb, rd_fall, ovf_set, unr_set;
  logic [CHANNELS-1:0] push_v, pop_v, acc_v;
  logic                any_full, all_empty;
  logic [7:0]          lvl0_ext;
  logic [3:0]          lvl0_sat;

  assign frame_stb = (div_q == DW'(RATE_DIV - 1));
  // One push per I/O cycle: the first cycle the registered hit is seen.
  assign push_stb  = wr_hit_q & ~wr_dly_q;

  // Port decode for writes and the status read; captured next edge.
  always_comb begin
    hit_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit_d[c] = bus_ioreq & bus_wr &
                 ((en_soundrive & (bus_a == CH_PORTS[c*8 +: 8])) |
                  (en_covox & (bus_a == COVOX_PORT)));
    end
    wr_hit_d = |hit_d;
    wr_dly_d = wr_hit_q;
    data_d   = bus_d;
    rd_act   = bus_ioreq & bus_rd & (bus_a == STAT_PORT);
    rd_d     = rd_act;
  end

  // Frame divider, channel FIFOs/outputs and sticky flag next-state.
  always_comb begin
    div_d   = frame_stb ? '0 : div_q + DW'(1);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    lvl_d   = lvl_q;
    out_d   = out_q;
    push_v  = '0;
    pop_v   = '0;
    acc_v   = '0;
    ovf_set = 1'b0;
    unr_set = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      push_v[c] = push_stb & hit_q[c];
      if (!en_fifo) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
        lvl_d[c]  = '0;
        if (push_v[c]) out_d[c] = data_q;
      end else begin
        pop_v[c] = frame_stb & (lvl_q[c] != '0);
        if (frame_stb && (lvl_q[c] == '0)) unr_set = 1'b1;
        if (pop_v[c]) begin
          out_d[c]  = mem_q[c][rptr_q[c]];
          rptr_d[c] = rptr_q[c] + AW'(1);
        end
        // A pop in the same cycle frees the slot a full FIFO needs.
        acc_v[c] = push_v[c] & ((lvl_q[c] != FULL_LVL) | pop_v[c]);
        if (push_v[c] && !acc_v[c]) ovf_set = 1'b1;
        if (acc_v[c]) begin
          mem_d[c][wptr_q[c]] = data_q;
          wptr_d[c]           = wptr_q[c] + AW'(1);
        end
        lvl_d[c] = lvl_q[c] + LW'(acc_v[c]) - LW'(pop_v[c]);
      end
    end
    rd_fall = rd_q & ~rd_act;
    ovf_d   = (ovf_q & ~rd_fall) | ovf_set;
    unr_d   = (unr_q & ~rd_fall) | unr_set;
  end

  // Status byte and channel output packing.
  always_comb begin
    any_full  = 1'b0;
    all_empty = 1'b1;
    ch_out    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      any_full  = any_full | (lvl_q[c] == FULL_LVL);
      all_empty = all_empty & (lvl_q[c] == '0);
      ch_out[c*8 +: 8] = out_q[c];
    end
    lvl0_ext = 8'(lvl_q[0]);
    lvl0_sat = (lvl0_ext > 8'd15) ? 4'hF : lvl0_ext[3:0];
    d_oe     = rd_act;
    d_out    = {any_full, all_empty, ovf_q, unr_q, lvl0_sat};
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk28) begin
    if (rst) begin
      hit_q    <= '0;
      wr_hit_q <= 1'b0;
      wr_dly_q <= 1'b0;
      data_q   <= '0;
      rd_q     <= 1'b0;
      div_q    <= '0;
      ovf_q    <= 1'b0;
      unr_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        lvl_q[c]  <= '0;
        out_q[c]  <= 8'h80;
      end
    end else begin
      hit_q    <= hit_d;
      wr_hit_q <= wr_hit_d;
      wr_dly_q <= wr_dly_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      unr_q    <= unr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lvl_q    <= lvl_d;
      out_q    <= out_d;
    end
  end

  // Sample storage; validity is tracked by the level counters, so no reset.
  always_ff @(posedge clk28) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_soundrive_fifo.sv
// Bench for soundrive_fifo: directed scenarios plus randomized bus traffic,
// checked against a queue-based transaction model of the channel behaviour.
module tb_soundrive_fifo;

  localparam int CH    = 4;
  localparam int DEPTH = 16;
  localparam int RD    = 635;

  logic          clk28 = 1'b0;
  logic          rst = 1'b1;
  logic          en_soundrive = 1'b1, en_covox = 1'b1, en_fifo = 1'b0;
  logic [7:0]    bus_a = 8'h00, bus_d = 8'h00;
  logic          bus_ioreq = 1'b0, bus_wr = 1'b0, bus_rd = 1'b0;
  logic [7:0]    d_out;
  logic          d_oe;
  logic [CH*8-1:0] ch_out;
  logic          frame_stb;

  int vectors = 0;
  int miscompares = 0;

  soundrive_fifo dut (
    .clk28(clk28), .rst(rst), .en_soundrive(en_soundrive), .en_covox(en_covox),
    .en_fifo(en_fifo), .bus_a(bus_a), .bus_d(bus_d), .bus_ioreq(bus_ioreq),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .d_out(d_out), .d_oe(d_oe),
    .ch_out(ch_out), .frame_stb(frame_stb)
  );

  initial forever #5 clk28 = ~clk28;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0] ports [CH] = '{8'h0F, 8'h1F, 8'h4F, 8'h5F};
  logic [7:0] m_out [CH];
  logic [7:0] m_q [CH][$];
  bit         m_ovf, m_unr;
  int         m_div;
  bit         m_pend, m_prev_hit, m_rd_prev;
  logic [CH-1:0] m_pmask;
  logic [7:0] m_pdata;

  always @(posedge clk28) begin
    bit frame;
    bit rd_now;
    bit push;
    logic [CH-1:0] mask;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_out[c] = 8'h80;
        m_q[c].delete();
      end
      m_ovf = 0; m_unr = 0; m_div = 0;
      m_pend = 0; m_prev_hit = 0; m_rd_prev = 0;
    end else begin
      frame  = (m_div == RD - 1);
      rd_now = bus_ioreq && bus_rd && (bus_a == 8'hBF);
      if (m_rd_prev && !rd_now) begin
        m_ovf = 0;
        m_unr = 0;
      end
      for (int c = 0; c < CH; c++) begin
        push = m_pend && m_pmask[c];
        if (!en_fifo) begin
          m_q[c].delete();
          if (push) m_out[c] = m_pdata;
        end else begin
          if (frame) begin
            if (m_q[c].size() > 0) m_out[c] = m_q[c].pop_front();
            else m_unr = 1;
          end
          if (push) begin
            if (m_q[c].size() < DEPTH) m_q[c].push_back(m_pdata);
            else m_ovf = 1;
          end
        end
      end
      m_div = frame ? 0 : m_div + 1;
      for (int c = 0; c < CH; c++)
        mask[c] = bus_ioreq && bus_wr &&
                  ((en_soundrive && bus_a == ports[c]) || (en_covox && bus_a == 8'hFB));
      m_pend     = (|mask) && !m_prev_hit;
      m_pmask    = mask;
      m_pdata    = bus_d;
      m_prev_hit = |mask;
      m_rd_prev  = rd_now;
    end
  end

  function automatic logic [CH*8-1:0] exp_ch();
    logic [CH*8-1:0] v;
    for (int c = 0; c < CH; c++) v[c*8 +: 8] = m_out[c];
    return v;
  endfunction

  function automatic logic [7:0] exp_stat();
    logic full, empty;
    int l0;
    full = 1'b0;
    empty = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (m_q[c].size() == DEPTH) full = 1'b1;
      if (m_q[c].size() != 0) empty = 1'b0;
    end
    l0 = m_q[0].size();
    if (l0 > 15) l0 = 15;
    return {full, empty, m_ovf, m_unr, 4'(l0)};
  endfunction

  // ---------------- bus drivers ----------------
  task automatic do_reset();
    @(negedge clk28);
    rst = 1'b1; bus_ioreq = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    repeat (2) @(negedge clk28);
    rst = 1'b0;
  endtask

  task automatic bus_out(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(negedge clk28);
    bus_a = a; bus_d = d; bus_ioreq = 1'b1; bus_wr = 1'b1; bus_rd = 1'b0;
    repeat (hold) @(negedge clk28);
    bus_ioreq = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic read_stat(output logic [7:0] got, output logic oe, output logic [7:0] exp);
    @(negedge clk28);
    bus_a = 8'hBF; bus_ioreq = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0;
    #1;
    got = d_out; oe = d_oe; exp = exp_stat();
    @(negedge clk28);
    bus_ioreq = 1'b0; bus_rd = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first = -1, second = -1;
    logic [7:0] got, exp;
    logic oe;
    en_fifo = 1'b0;
    do_reset();
    vectors++;
    if (ch_out !== {CH{8'h80}}) begin
      miscompares++; $display("FAIL reset_ch_out got %h want %h", ch_out, {CH{8'h80}});
    end
    vectors++;
    if (frame_stb !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_stb got %b want 0", frame_stb);
    end
    vectors++;
    if (d_oe !== 1'b0) begin
      miscompares++; $display("FAIL reset_d_oe got %b want 0", d_oe);
    end
    for (int k = 1; k <= 1400 && second < 0; k++) begin
      @(negedge clk28);
      if (frame_stb === 1'b1) begin
        if (first < 0) first = k; else second = k;
      end
    end
    vectors++;
    if (first != RD - 1) begin
      miscompares++; $display("FAIL reset_first_frame got %0d want %0d", first, RD - 1);
    end
    vectors++;
    if (second - first != RD) begin
      miscompares++; $display("FAIL frame_period got %0d want %0d", second - first, RD);
    end
    read_stat(got, oe, exp);
    vectors++;
    if (oe !== 1'b1) begin
      miscompares++; $display("FAIL reset_stat_oe got %b want 1", oe);
    end
    vectors++;
    if (got !== 8'h40) begin
      miscompares++; $display("FAIL reset_status got %h want 40", got);
    end
  endtask

  task automatic test_legacy();
    en_fifo = 1'b0;
    @(negedge clk28);
    bus_a = 8'h0F; bus_d = 8'h12; bus_ioreq = 1'b1; bus_wr = 1'b1;
    @(negedge clk28);
    vectors++;
    if (ch_out[7:0] !== 8'h80) begin
      miscompares++; $display("FAIL legacy_early got %h want 80", ch_out[7:0]);
    end
    @(negedge clk28);
    vectors++;
    if (ch_out[7:0] !== 8'h12) begin
      miscompares++; $display("FAIL legacy_direct got %h want 12", ch_out[7:0]);
    end
    bus_d = 8'h77;
    repeat (4) @(negedge clk28);
    bus_ioreq = 1'b0; bus_wr = 1'b0;
    @(negedge clk28);
    vectors++;
    if (ch_out !== {8'h80, 8'h80, 8'h80, 8'h12} || ch_out !== exp_ch()) begin
      miscompares++; $display("FAIL legacy_single_push got %h want %h", ch_out, {8'h80, 8'h80, 8'h80, 8'h12});
    end
    bus_out(8'hFB, 8'h34, 6);
    @(negedge clk28);
    vectors++;
    if (ch_out !== {CH{8'h34}}) begin
      miscompares++; $display("FAIL legacy_covox got %h want %h", ch_out, {CH{8'h34}});
    end
    en_soundrive = 1'b0;
    bus_out(8'h1F, 8'h99, 3);
    @(negedge clk28);
    en_soundrive = 1'b1;
    vectors++;
    if (ch_out !== {CH{8'h34}} || ch_out !== exp_ch()) begin
      miscompares++; $display("FAIL legacy_disabled got %h want %h", ch_out, {CH{8'h34}});
    end
  endtask

  task automatic test_fifo_seq();
    logic [7:0] seen [$];
    logic [7:0] last, got, exp;
    logic oe;
    bit bad = 0;
    do_reset();
    en_fifo = 1'b1;
    bus_out(8'h1F, 8'h01, 3);
    bus_out(8'h1F, 8'h02, 3);
    bus_out(8'h1F, 8'h03, 3);
    last = ch_out[15:8];
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk28);
      if (!bad) begin
        vectors++;
        if (ch_out !== exp_ch()) begin
          bad = 1; miscompares++;
          $display("FAIL fifo_seq_track got %h want %h", ch_out, exp_ch());
        end
      end
      if (ch_out[15:8] !== last) begin
        seen.push_back(ch_out[15:8]);
        last = ch_out[15:8];
      end
    end
    vectors++;
    if (seen.size() != 3 || seen[0] !== 8'h01 || seen[1] !== 8'h02 || seen[2] !== 8'h03) begin
      miscompares++; $display("FAIL fifo_seq_order got %0d changes last %h want 01,02,03", seen.size(), last);
    end
    read_stat(got, oe, exp);
    vectors++;
    if (got[4] !== 1'b1 || got !== exp) begin
      miscompares++; $display("FAIL fifo_seq_unr got %h want %h", got, exp);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] seen [$];
    logic [7:0] last, got, exp;
    logic oe;
    bit bad = 0;
    do_reset();
    en_fifo = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) bus_out(8'h0F, 8'(8'h20 + i), 2);
    @(negedge clk28);
    read_stat(got, oe, exp);
    vectors++;
    if (got !== 8'hAF || got !== exp) begin
      miscompares++; $display("FAIL overflow_status got %h want af", got);
    end
    last = ch_out[7:0];
    for (int k = 0; k < (DEPTH + 1) * RD; k++) begin
      @(negedge clk28);
      if (!bad) begin
        vectors++;
        if (ch_out !== exp_ch()) begin
          bad = 1; miscompares++;
          $display("FAIL overflow_track got %h want %h", ch_out, exp_ch());
        end
      end
      if (ch_out[7:0] !== last) begin
        seen.push_back(ch_out[7:0]);
        last = ch_out[7:0];
      end
    end
    vectors++;
    if (seen.size() != DEPTH || last !== 8'h2F) begin
      miscompares++; $display("FAIL overflow_drain got %0d samples last %h want 16 last 2f", seen.size(), last);
    end
  endtask

  task automatic test_full_coincide();
    logic [7:0] got, exp;
    logic oe;
    do_reset();
    en_fifo = 1'b1;
    for (int i = 0; i < DEPTH; i++) bus_out(8'h0F, 8'(8'h40 + i), 2);
    for (int k = 0; k < 2 * RD && m_div != RD - 2; k++) @(negedge clk28);
    vectors++;
    if (m_div != RD - 2) begin
      miscompares++; $display("FAIL coincide_wait got div %0d want %0d", m_div, RD - 2);
    end
    bus_a = 8'h0F; bus_d = 8'hEE; bus_ioreq = 1'b1; bus_wr = 1'b1;
    @(negedge clk28);
    vectors++;
    if (frame_stb !== 1'b1) begin
      miscompares++; $display("FAIL coincide_frame got %b want 1", frame_stb);
    end
    @(negedge clk28);
    bus_ioreq = 1'b0; bus_wr = 1'b0;
    vectors++;
    if (ch_out[7:0] !== 8'h40) begin
      miscompares++; $display("FAIL coincide_pop got %h want 40", ch_out[7:0]);
    end
    read_stat(got, oe, exp);
    vectors++;
    if (got !== 8'h9F || got !== exp) begin
      miscompares++; $display("FAIL coincide_status got %h want 9f", got);
    end
    read_stat(got, oe, exp);
    vectors++;
    if (got !== 8'h8F || got !== exp) begin
      miscompares++; $display("FAIL coincide_clear got %h want 8f", got);
    end
  endtask

  task automatic test_mode_change();
    logic [7:0] got, exp;
    logic oe;
    int first = -1;
    do_reset();
    en_fifo = 1'b1;
    for (int i = 0; i < 6; i++) bus_out(8'h4F, 8'(8'h61 + i), 2);
    for (int k = 0; k < 2 * RD && frame_stb !== 1'b1; k++) @(negedge clk28);
    @(negedge clk28);
    en_fifo = 1'b0;
    repeat (2) @(negedge clk28);
    vectors++;
    if (ch_out[23:16] !== 8'h61 || ch_out !== exp_ch()) begin
      miscompares++; $display("FAIL mode_hold got %h want 61", ch_out[23:16]);
    end
    read_stat(got, oe, exp);
    vectors++;
    if (got !== 8'h50 || got !== exp) begin
      miscompares++; $display("FAIL mode_flush_status got %h want 50", got);
    end
    en_fifo = 1'b1;
    for (int k = 0; k < 2 * RD && frame_stb !== 1'b1; k++) @(negedge clk28);
    @(negedge clk28);
    vectors++;
    if (ch_out[23:16] !== 8'h61) begin
      miscompares++; $display("FAIL mode_flushed got %h want 61", ch_out[23:16]);
    end
    for (int k = 0; k < 2 * RD && m_div != 300; k++) @(negedge clk28);
    do_reset();
    vectors++;
    if (ch_out !== {CH{8'h80}}) begin
      miscompares++; $display("FAIL midframe_reset got %h want %h", ch_out, {CH{8'h80}});
    end
    for (int k = 1; k <= 2 * RD && first < 0; k++) begin
      @(negedge clk28);
      if (frame_stb === 1'b1) first = k;
    end
    vectors++;
    if (first != RD - 1) begin
      miscompares++; $display("FAIL midframe_restart got %0d want %0d", first, RD - 1);
    end
  endtask

  task automatic test_random(input int ncyc);
    logic [7:0] pick [7] = '{8'h0F, 8'h1F, 8'h4F, 8'h5F, 8'hFB, 8'hBF, 8'h00};
    int left = 0;
    int r;
    bit bad = 0;
    bit exp_oe;
    do_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk28);
      if (!bad) begin
        exp_oe = bus_ioreq && bus_rd && (bus_a == 8'hBF);
        vectors++;
        if (ch_out !== exp_ch()) begin
          bad = 1; miscompares++;
          $display("FAIL rand_ch_out cyc %0d got %h want %h", i, ch_out, exp_ch());
        end else if (frame_stb !== (m_div == RD - 1)) begin
          bad = 1; miscompares++;
          $display("FAIL rand_frame_stb cyc %0d got %b want %b", i, frame_stb, m_div == RD - 1);
        end else if (d_oe !== exp_oe) begin
          bad = 1; miscompares++;
          $display("FAIL rand_d_oe cyc %0d got %b want %b", i, d_oe, exp_oe);
        end else if (exp_oe && d_out !== exp_stat()) begin
          bad = 1; miscompares++;
          $display("FAIL rand_status cyc %0d got %h want %h", i, d_out, exp_stat());
        end
      end
      if (left > 0) left--;
      if (left == 0) begin
        if (bus_ioreq) begin
          bus_ioreq = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
        end else begin
          r = $urandom_range(0, 99);
          if (r < 4) en_fifo = ~en_fifo;
          if (r < 8) begin
            en_soundrive = ($urandom_range(0, 3) != 0);
            en_covox = ($urandom_range(0, 3) != 0);
          end
          if (r < 25) begin
            bus_a = pick[$urandom_range(0, 6)];
            bus_d = 8'($urandom);
            bus_ioreq = 1'b1; bus_wr = 1'b1;
            left = $urandom_range(1, 6);
          end else if (r < 35) begin
            bus_a = 8'hBF; bus_ioreq = 1'b1; bus_rd = 1'b1;
            left = $urandom_range(1, 3);
          end else begin
            left = $urandom_range(1, 60);
          end
        end
      end
    end
    bus_ioreq = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    en_soundrive = 1'b1; en_covox = 1'b1;
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_fifo_seq();
    test_overflow();
    test_full_coincide();
    test_mode_change();
    en_fifo = 1'b1;
    test_random(15000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
